// File: rtl/logic_unit_simd_pkg.sv
// rtl/logic_unit_simd_pkg.sv - operation and lane-size types for the SIMD logic unit
package logic_unit_simd_pkg;

   typedef enum logic [3:0] {
      AND    = 4'd0,
      OR     = 4'd1,
      XOR    = 4'd2,
      LSHFTL = 4'd3,
      LSHFTR = 4'd4,
      ASHFTR = 4'd5,
      ROTL   = 4'd6,
      ROTR   = 4'd7,
      S_LT   = 4'd8,
      S_GT   = 4'd9,
      U_LT   = 4'd10,
      U_GT   = 4'd11,
      EQ     = 4'd12,
      MAX3   = 4'd13
   } logic_op_t;

   typedef enum logic [1:0] {
      E8  = 2'd0,
      E16 = 2'd1,
      E32 = 2'd2,
      E64 = 2'd3
   } elem_sz_t;

   function automatic int unsigned elem_lw(elem_sz_t esz);
      return 32'd8 << esz;
   endfunction

endpackage

// File: rtl/logic_unit_simd_if.sv
// rtl/logic_unit_simd_if.sv - operation/result handshake bundle of the SIMD logic unit
interface logic_unit_simd_if #(
   parameter int WIDTH = 64,
   parameter int TAG_W = 6
) ();
   import logic_unit_simd_pkg::*;

   logic             in_valid;
   logic             in_ready;
   logic_op_t        op;
   elem_sz_t         elem_sz;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] c;
   logic [TAG_W-1:0] tag;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic [TAG_W-1:0] out_tag;

   modport master (
      output in_valid, op, elem_sz, a, b, c, tag, out_ready,
      input  in_ready, out_valid, out_data, out_tag
   );

   modport slave (
      input  in_valid, op, elem_sz, a, b, c, tag, out_ready,
      output in_ready, out_valid, out_data, out_tag
   );
endinterface

// File: rtl/logic_unit_simd_lane.sv
// rtl/logic_unit_simd_lane.sv - combinational single-lane logic/shift/compare/max3 unit
module logic_simd_lane
   import logic_unit_simd_pkg::*;
#(
   parameter int LW = 8
) (
   input  logic_op_t   op_i,
   input  logic [LW-1:0] a_i,
   input  logic [LW-1:0] b_i,
   input  logic [LW-1:0] c_i,
   output logic [LW-1:0] y_o
);
   localparam int SW = $clog2(LW);

   logic [SW-1:0]   sh;
   logic [2*LW-1:0] rotl_w;
   logic [2*LW-1:0] rotr_w;
   logic [LW-1:0]   max_ab;

   // Shifting a doubled copy turns a rotate into a plain shift plus a slice.
   assign sh     = b_i[SW-1:0];
   assign rotl_w = {a_i, a_i} << sh;
   assign rotr_w = {a_i, a_i} >> sh;
   assign max_ab = ($signed(b_i) > $signed(a_i)) ? b_i : a_i;

   always_comb begin
      y_o = '0;
      case (op_i)
         AND:     y_o = a_i & b_i;
         OR:      y_o = a_i | b_i;
         XOR:     y_o = a_i ^ b_i;
         LSHFTL:  y_o = a_i << sh;
         LSHFTR:  y_o = a_i >> sh;
         ASHFTR:  y_o = $signed(a_i) >>> sh;
         ROTL:    y_o = rotl_w[2*LW-1:LW];
         ROTR:    y_o = rotr_w[LW-1:0];
         S_LT:    y_o = {{(LW-1){1'b0}}, $signed(a_i) < $signed(b_i)};
         S_GT:    y_o = {{(LW-1){1'b0}}, $signed(a_i) > $signed(b_i)};
         U_LT:    y_o = {{(LW-1){1'b0}}, a_i < b_i};
         U_GT:    y_o = {{(LW-1){1'b0}}, a_i > b_i};
         EQ:      y_o = {{(LW-1){1'b0}}, a_i == b_i};
         // Strict compares keep the earlier operand on ties.
         MAX3:    y_o = ($signed(c_i) > $signed(max_ab)) ? c_i : max_ab;
         default: y_o = '0;
      endcase
   end
endmodule

// File: rtl/logic_unit_simd.sv
// rtl/logic_unit_simd.sv - two-stage lane-parallel logic unit with valid/ready, flush and tag
module logic_unit_simd
   import logic_unit_simd_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int TAG_W = 6
) (
   input logic               clk,
   input logic               rst_n,
   input logic               flush,
   logic_unit_simd_if.slave  io
);
   logic             a_valid_q, a_valid_d;
   logic_op_t        a_op_q, a_op_d;
   elem_sz_t         a_esz_q, a_esz_d;
   logic [WIDTH-1:0] a_a_q, a_a_d;
   logic [WIDTH-1:0] a_b_q, a_b_d;
   logic [WIDTH-1:0] a_c_q, a_c_d;
   logic [TAG_W-1:0] a_tag_q, a_tag_d;
   logic             b_valid_q, b_valid_d;
   logic [WIDTH-1:0] b_data_q, b_data_d;
   logic [TAG_W-1:0] b_tag_q, b_tag_d;

   logic             b_load;
   logic             in_ready;
   logic [3:0][WIDTH-1:0] res;
   logic [WIDTH-1:0] lane_res;

   for (genvar s = 0; s < 4; s++) begin : g_sz
      localparam int LW = 8 << s;
      for (genvar i = 0; i < WIDTH / LW; i++) begin : g_lane
         logic_simd_lane #(.LW(LW)) u_lane (
            .op_i (a_op_q),
            .a_i  (a_a_q[i*LW +: LW]),
            .b_i  (a_b_q[i*LW +: LW]),
            .c_i  (a_c_q[i*LW +: LW]),
            .y_o  (res[s][i*LW +: LW])
         );
      end
   end

   assign lane_res = res[a_esz_q];

   // in_ready looks only at state, flush and out_ready, never at in_valid.
   assign b_load   = !b_valid_q || io.out_ready;
   assign in_ready = !flush && (!a_valid_q || b_load);

   assign io.in_ready  = in_ready;
   assign io.out_valid = b_valid_q;
   assign io.out_data  = b_data_q;
   assign io.out_tag   = b_tag_q;

   always_comb begin
      a_valid_d = a_valid_q;
      a_op_d    = a_op_q;
      a_esz_d   = a_esz_q;
      a_a_d     = a_a_q;
      a_b_d     = a_b_q;
      a_c_d     = a_c_q;
      a_tag_d   = a_tag_q;
      b_valid_d = b_valid_q;
      b_data_d  = b_data_q;
      b_tag_d   = b_tag_q;
      if (flush) begin
         a_valid_d = 1'b0;
         b_valid_d = 1'b0;
      end else begin
         if (b_load) begin
            b_valid_d = a_valid_q;
            if (a_valid_q) begin
               b_data_d = lane_res;
               b_tag_d  = a_tag_q;
            end
         end
         if (in_ready) begin
            a_valid_d = io.in_valid;
            if (io.in_valid) begin
               a_op_d  = io.op;
               a_esz_d = io.elem_sz;
               a_a_d   = io.a;
               a_b_d   = io.b;
               a_c_d   = io.c;
               a_tag_d = io.tag;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_valid_q <= 1'b0;
         a_op_q    <= AND;
         a_esz_q   <= E8;
         a_a_q     <= '0;
         a_b_q     <= '0;
         a_c_q     <= '0;
         a_tag_q   <= '0;
         b_valid_q <= 1'b0;
         b_data_q  <= '0;
         b_tag_q   <= '0;
      end else begin
         a_valid_q <= a_valid_d;
         a_op_q    <= a_op_d;
         a_esz_q   <= a_esz_d;
         a_a_q     <= a_a_d;
         a_b_q     <= a_b_d;
         a_c_q     <= a_c_d;
         a_tag_q   <= a_tag_d;
         b_valid_q <= b_valid_d;
         b_data_q  <= b_data_d;
         b_tag_q   <= b_tag_d;
      end
   end
endmodule

// File: doc/logic_unit_simd.md
Name: logic_unit_simd

Overview:
- Pipelined, lane-parallel successor to the scalar logic unit, sitting in the execute stage beside the adder and multiplier.
- Splits each WIDTH-bit operand into lanes of a runtime-selected element size (8/16/32/64 bits) and applies the logic/shift/compare/MAX3 operation per lane.
- Adds rotates, masked per-lane shift amounts, valid/ready handshaking with full backpressure, a flush input and a passthrough tag for result routing.

Parameters:
- WIDTH, 64, operand/result width in bits; must be a multiple of 64.
- TAG_W, 6, width of the tag carried alongside each operation.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  discard every in-flight operation.
- in_valid  in  1  operation presented.
- in_ready  out  1  unit accepts the operation this cycle.
- op  in  logic_op_t  operation select.
- elem_sz  in  elem_sz_t  lane width select: E8, E16, E32 or E64.
- a  in  WIDTH  operand a.
- b  in  WIDTH  operand b; also the per-lane shift amount.
- c  in  WIDTH  operand c, used by MAX3 only.
- tag  in  TAG_W  caller tag, returned unchanged.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  WIDTH  result.
- out_tag  out  TAG_W  tag of the result.

Behaviour:
- Reset is asynchronous, active-low: one clock, asynchronous assertion, synchronous deassertion by the integrator.
  - While rst_n=0: all valid bits are 0, so in_ready=1 and out_valid=0; out_data=0; out_tag=0.
  - An operation in flight when reset asserts is lost.
- Two stages:
  - Stage A registers op, elem_sz, a, b, c and tag.
  - The combinational lane datapath operates on stage A; its result and the tag are registered into stage B, which drives the out_* ports.
- Latency and throughput:
  - An input accepted at clock edge N produces out_valid=1 after edge N+1.
  - Throughput is 1 operation per cycle when out_ready=1.
- Handshake:
  - Stage B loads when b_valid=0 or out_ready=1.
  - Stage A advances when stage B loads.
  - in_ready = !flush && (!a_valid || B loads).
  - Transfers occur only when valid and ready are both high.
  - out_data and out_tag stay stable while out_valid=1 and out_ready=0.
  - in_ready must not depend combinationally on in_valid.
- Flush:
  - At the next edge, a_valid and b_valid are cleared.
  - in_ready=0 during the flush cycle, so no input is accepted.
  - out_data keeps its last value, but out_valid=0.
- Lane semantics, with lane width LW = 8/16/32/64:
  - Shifts and rotates use the low log2(LW) bits of b's lane as the shift amount. Bits never cross lane boundaries.
  - ASHFTR sign-fills from the lane MSB.
  - AND/OR/XOR are bitwise and independent of elem_sz.
  - ROTL/ROTR rotate within the lane.
  - S_LT, S_GT, U_LT, U_GT and EQ write 1 or 0 into the lane LSB; the rest of the lane is 0.
  - MAX3 selects the signed maximum per lane. On a tie it prefers a over b over c.
- An undefined op encoding produces a 0 result but still completes the handshake with its tag.

Decomposition:
- arithmetic_pkg:
  - Extend logic_op_t with ROTL and ROTR.
  - Add elem_sz_t and a function returning LW for each elem_sz_t.
- Sub-module logic_simd_lane #(LW):
  - A purely combinational single-lane compute unit.
  - Instantiated WIDTH/LW times for each LW in {8, 16, 32, 64}.
  - The parent muxes the four lane-width results by stage-A elem_sz.
  - The parent holds all handshake and pipeline registers.

Test Plan:
- E64 LSHFTL, a=1, b=65 → shift amount masked to 1, out_data=2, out_valid exactly 2 cycles after acceptance. E8 ROTL, a=64'h8181818181818181, b=64'h0101010101010101 → 64'h0303030303030303.
- E8 ASHFTR, a=64'h8080808080808080, b=64'h0101010101010101 → 64'hC0C0C0C0C0C0C0C0. The same operands with E16 → 64'hC040C040C040C040.
- E16 S_LT, a=64'hFFFF_0001_0000_7FFF, b=64'h0000_0000_0000_8000 → 64'h0001_0000_0000_0000. The same operands with U_LT → 64'h0000_0000_0000_0001.
- E32 MAX3, a=64'hFFFFFFFF_00000005, b=64'h00000001_00000007, c=64'h00000000_00000006 → 64'h00000001_00000007. All three operands equal → result is a.
- Backpressure: stream tags 1..4 back-to-back while out_ready=0 for 3 cycles.
  - in_ready drops once both stages are full.
  - out_data/out_tag stay stable while stalled.
  - Tags emerge in order 1..4 with no loss or duplication.
- Flush with 2 operations in flight → out_valid=0 next cycle and in_ready=0 in the flush cycle; a subsequent op completes normally. rst_n pulsed low mid-stream → out_valid=0, out_data=0 and out_tag=0 immediately, without waiting for a clock edge.
